// File: rtl/max_33_s2.sv
// 3x3 stride-2 signed max pool over a WIDTH x WIDTH raster stream, one output per qualifying pixel.
// Latency 1 clock from the qualifying valid_in; no backpressure, idle cycles simply freeze all state.
module max_33_s2 #(
  parameter int WIDTH      = 71,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  typedef logic signed [DATA_WIDTH-1:0] pix_t;

  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  pix_t          lb0_q [WIDTH];
  pix_t          lb1_q [WIDTH];
  pix_t          win_q [3][2];
  pix_t          win_d [3][2];
  pix_t          col   [3];
  pix_t          max_val;
  pix_t          pxl_out_q, pxl_out_d;
  logic          valid_out_q, valid_out_d;
  logic          fire;

  // lb1 holds row r-2, lb0 holds row r-1, both at the current column
  always_comb begin
    col[0] = lb1_q[c_q];
    col[1] = lb0_q[c_q];
    col[2] = pix_t'(pxl_in);
  end

  always_comb begin
    fire = valid_in && (r_q >= TWO) && (c_q >= TWO) && !r_q[0] && !c_q[0];
    max_val = col[0];
    for (int k = 0; k < 3; k++) begin
      if (col[k] > max_val) max_val = col[k];
      for (int j = 0; j < 2; j++) begin
        if (win_q[k][j] > max_val) max_val = win_q[k][j];
      end
    end
  end

  always_comb begin
    r_d         = r_q;
    c_d         = c_q;
    win_d       = win_q;
    valid_out_d = 1'b0;
    pxl_out_d   = pxl_out_q;
    if (valid_in) begin
      if (c_q == LAST) begin
        c_d = '0;
        r_d = (r_q == LAST) ? '0 : r_q + CW'(1);
      end else begin
        c_d = c_q + CW'(1);
      end
      for (int k = 0; k < 3; k++) begin
        win_d[k][0] = win_q[k][1];
        win_d[k][1] = col[k];
      end
      if (fire) begin
        valid_out_d = 1'b1;
        pxl_out_d   = max_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q         <= '0;
      c_q         <= '0;
      valid_out_q <= 1'b0;
      pxl_out_q   <= '0;
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 2; j++) begin
          win_q[k][j] <= '0;
        end
      end
    end else begin
      r_q         <= r_d;
      c_q         <= c_d;
      valid_out_q <= valid_out_d;
      pxl_out_q   <= pxl_out_d;
      win_q       <= win_d;
    end
  end

  // Line buffers are never cleared; rows 0..1 of every frame refill them before any output qualifies
  always_ff @(posedge clk) begin
    if (valid_in && !reset) begin
      lb0_q[c_q] <= pix_t'(pxl_in);
      lb1_q[c_q] <= lb0_q[c_q];
    end
  end

  assign pxl_out   = pxl_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_max_33_s2.sv
// Scoreboard bench: drivers push expected pooled values from a frame-array model, monitors pop and compare.
module tb_max_33_s2;

  typedef struct {
    logic [31:0] v;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  logic        rst5, vin5, vo5;
  logic [31:0] pin5, po5;
  logic        rst71, vin71, vo71;
  logic [31:0] pin71, po71;

  exp_t        q5[$];
  exp_t        q71[$];
  int          f5  [5][5];
  int          f71 [71][71];
  int          r5 = 0, c5 = 0, r71 = 0, c71 = 0;
  logic [31:0] hold5 = 32'd0;
  int          out71 = 0;

  max_33_s2 #(.WIDTH(5), .DATA_WIDTH(32)) dut5 (
    .clk(clk), .reset(rst5), .valid_in(vin5), .pxl_in(pin5),
    .pxl_out(po5), .valid_out(vo5)
  );

  max_33_s2 dut71 (
    .clk(clk), .reset(rst71), .valid_in(vin71), .pxl_in(pin71),
    .pxl_out(po71), .valid_out(vo71)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic int wmax5(input int r, input int c);
    int m = f5[r-2][c-2];
    for (int dr = -2; dr <= 0; dr++)
      for (int dc = -2; dc <= 0; dc++)
        if (f5[r+dr][c+dc] > m) m = f5[r+dr][c+dc];
    return m;
  endfunction

  function automatic int wmax71(input int r, input int c);
    int m = f71[r-2][c-2];
    for (int dr = -2; dr <= 0; dr++)
      for (int dc = -2; dc <= 0; dc++)
        if (f71[r+dr][c+dc] > m) m = f71[r+dr][c+dc];
    return m;
  endfunction

  // Called #1 after a rising edge; the pixel is sampled on the next edge
  task automatic drive5(input bit v, input logic [31:0] px);
    exp_t e;
    vin5 = v;
    pin5 = v ? px : $urandom;
    if (v) begin
      f5[r5][c5] = px;
      if (r5 >= 2 && c5 >= 2 && r5 % 2 == 0 && c5 % 2 == 0) begin
        e.v = wmax5(r5, c5);
        e.cyc = cyc + 1;
        q5.push_back(e);
      end
      c5++;
      if (c5 == 5) begin c5 = 0; r5 = (r5 + 1) % 5; end
    end
    @(posedge clk); #1;
  endtask

  task automatic drive71(input bit v, input logic [31:0] px);
    exp_t e;
    vin71 = v;
    pin71 = v ? px : $urandom;
    if (v) begin
      f71[r71][c71] = px;
      if (r71 >= 2 && c71 >= 2 && r71 % 2 == 0 && c71 % 2 == 0) begin
        e.v = wmax71(r71, c71);
        e.cyc = cyc + 1;
        q71.push_back(e);
      end
      c71++;
      if (c71 == 71) begin c71 = 0; r71 = (r71 + 1) % 71; end
    end
    @(posedge clk); #1;
  endtask

  task automatic ramp5(input int base);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        drive5(1'b1, base + 5*r + c);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (vo5) begin
        if (q5.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out5: got %0h with nothing expected at cycle %0d", po5, cyc);
        end else begin
          e = q5.pop_front();
          chk("out5_value", po5, e.v);
          chk("out5_cycle", cyc, e.cyc);
          hold5 = e.v;
        end
      end else begin
        chk("out5_hold", po5, hold5);
      end
      if (vo71) begin
        out71++;
        if (q71.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out71: got %0h with nothing expected at cycle %0d", po71, cyc);
        end else begin
          e = q71.pop_front();
          chk("out71_value", po71, e.v);
          chk("out71_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    rst5 = 1'b1; vin5 = 1'b0; pin5 = '0;
    rst71 = 1'b1; vin71 = 1'b0; pin71 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst5 = 1'b0; rst71 = 1'b0;
    chk("reset_vo5", {31'd0, vo5}, 32'd0);
    chk("reset_po5", po5, 32'd0);
    chk("reset_vo71", {31'd0, vo71}, 32'd0);
    chk("reset_po71", po71, 32'd0);
    mon_en = 1'b1;

    // ramp, then a second ramp frame back-to-back
    ramp5(0);
    ramp5(100);

    // mostly -7 with one -1
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        drive5(1'b1, (r == 3 && c == 3) ? -1 : -7);

    // most negative value everywhere
    for (int i = 0; i < 25; i++) drive5(1'b1, 32'h8000_0000);

    // gapped ramp: 1,0,0
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        drive5(1'b1, 5*r + c);
        drive5(1'b0, 0);
        drive5(1'b0, 0);
      end

    // abort after pixel (3,1); valid_in held high during reset must be ignored
    for (int i = 0; i < 17; i++) drive5(1'b1, 5*(i/5) + i%5);
    rst5 = 1'b1; vin5 = 1'b1; pin5 = $urandom;
    @(posedge clk); #1;
    rst5 = 1'b0; vin5 = 1'b0;
    r5 = 0; c5 = 0; hold5 = 32'd0;
    chk("midreset_vo5", {31'd0, vo5}, 32'd0);
    chk("midreset_po5", po5, 32'd0);
    ramp5(0);

    // random signed data with random gaps
    for (int i = 0; i < 75; i++) begin
      if ($urandom_range(0, 3) == 0) drive5(1'b0, 0);
      drive5(1'b1, $urandom);
    end
    while (r5 != 0 || c5 != 0) drive5(1'b1, $urandom);
    vin5 = 1'b0;

    // full-size frame of random signed data
    for (int i = 0; i < 71*71; i++) begin
      if ($urandom_range(0, 15) == 0) drive71(1'b0, 0);
      drive71(1'b1, $urandom);
    end
    vin71 = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("q5_drained", q5.size(), 32'd0);
    chk("q71_drained", q71.size(), 32'd0);
    chk("out71_count", out71, 32'd1225);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
